ua_rx: RTL

- UART receiver: the far-end counterpart of the serial word transmitter.
- Deserialises 8N1 frames from a single line at a selectable baud rate.
- Reassembles every four consecutive bytes into a 32-bit word so PRNG output can be looped back and checked.
- Sits at the board pin (bit_in) and presents bytes and words to a checker or host-side logic.

---
 rtl/ua_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ua_rx.sv
// UART 8N1 receiver with selectable baud rate; bytes are packed
// little-endian into 32-bit words for loopback checking.
module ua_rx #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic [2:0]  baud_sel,
  input  logic        rx_clear,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        framing_err,
  output logic        UA_RX_busy
);

  localparam int unsigned DIV0 = CLK_HZ / 9600;
  localparam int unsigned DIV1 = CLK_HZ / 19200;
  localparam int unsigned DIV2 = CLK_HZ / 38400;
  localparam int unsigned DIV3 = CLK_HZ / 57600;
  localparam int unsigned DIV4 = CLK_HZ / 115200;
  localparam int unsigned DIV5 = CLK_HZ / 230400;
  localparam int unsigned DIV6 = CLK_HZ / 460800;
  localparam int unsigned DIV7 = CLK_HZ / 921600;
  localparam int unsigned CW   = $clog2(DIV0 + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  function automatic logic [CW-1:0] div_of(input logic [2:0] sel);
    case (sel)
      3'd0:    div_of = CW'(DIV0);
      3'd1:    div_of = CW'(DIV1);
      3'd2:    div_of = CW'(DIV2);
      3'd3:    div_of = CW'(DIV3);
      3'd4:    div_of = CW'(DIV4);
      3'd5:    div_of = CW'(DIV5);
      3'd6:    div_of = CW'(DIV6);
      default: div_of = CW'(DIV7);
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   rx_q;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] div, div_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic [1:0]    idx, idx_n;
  logic [23:0]   word_buf, word_buf_n;
  logic [7:0]    byte_out_n;
  logic [31:0]   word_out_n;
  logic          byte_valid_n, word_valid_n, framing_err_n;
  logic [CW-1:0] sel_div;

  assign rx_s    = sync[SYNC_STAGES-1];
  assign sel_div = div_of(baud_sel);

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    div_n         = div;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    idx_n         = rx_clear ? 2'd0 : idx;
    word_buf_n    = word_buf;
    byte_out_n    = byte_out;
    word_out_n    = word_out;
    byte_valid_n  = 1'b0;
    word_valid_n  = 1'b0;
    framing_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        // Only a falling edge starts a frame, so a held-low line cannot retrigger
        if (rx_q && !rx_s) begin
          state_n = S_START;
          div_n   = sel_div;
          cnt_n   = CW'((sel_div >> 1) - CW'(1));
        end
      end
      S_START: begin
        if (cnt != '0) begin
          cnt_n = CW'(cnt - CW'(1));
        end else if (rx_s) begin
          state_n = S_IDLE;
        end else begin
          state_n   = S_DATA;
          bit_cnt_n = 3'd0;
          cnt_n     = CW'(div - CW'(1));
        end
      end
      S_DATA: begin
        if (cnt != '0) begin
          cnt_n = CW'(cnt - CW'(1));
        end else begin
          shift_n[bit_cnt] = rx_s;
          cnt_n            = CW'(div - CW'(1));
          bit_cnt_n        = 3'(bit_cnt + 3'd1);
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt != '0) begin
          cnt_n = CW'(cnt - CW'(1));
        end else begin
          state_n = S_IDLE;
          if (rx_s) begin
            byte_out_n   = shift;
            byte_valid_n = 1'b1;
            case (idx_n)
              2'd0:    word_buf_n[7:0]   = shift;
              2'd1:    word_buf_n[15:8]  = shift;
              2'd2:    word_buf_n[23:16] = shift;
              default: begin
                word_out_n   = {shift, word_buf};
                word_valid_n = 1'b1;
              end
            endcase
            idx_n = 2'(idx_n + 2'd1);
          end else begin
            framing_err_n = 1'b1;
            idx_n         = 2'd0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync        <= '1;
      rx_q        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      idx         <= '0;
      word_buf    <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      framing_err <= 1'b0;
      UA_RX_busy  <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], bit_in};
      rx_q        <= rx_s;
      state       <= state_n;
      cnt         <= cnt_n;
      div         <= div_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      idx         <= idx_n;
      word_buf    <= word_buf_n;
      byte_out    <= byte_out_n;
      byte_valid  <= byte_valid_n;
      word_out    <= word_out_n;
      word_valid  <= word_valid_n;
      framing_err <= framing_err_n;
      UA_RX_busy  <= (state_n != S_IDLE);
    end
  end

endmodule
